ct_clk_lpmd_ctrl: RTL and testbench

- Low-power-mode sequencer sitting directly upstream of the core global ICG.
- Runs on the ungated forever_coreclk. Takes the core's WFI low-power request and wakeup sources, and produces the registered clock-enable request (clk_lpmd_normal_work) that drives the ICG's enable OR-tree.
- Sequences drain, gate-off delay, sleep, snoop service and wake-up settling, so the core clock never stops with bus traffic pending and always restarts before the core is released.

---
 rtl/ct_clk_lpmd_pkg.sv | 17 +
 rtl/ct_clk_lpmd_cnt.sv | 31 +++
 rtl/ct_clk_lpmd_ctrl.sv | 137 +++++++++++++
 tb/tb_ct_clk_lpmd_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ct_clk_lpmd_pkg.sv
// Shared types and defaults for the core low-power-mode clock sequencer.
package ct_clk_lpmd_pkg;

    localparam int LPMD_CNT_W    = 4;
    localparam int LPMD_OFF_DLY  = 4;
    localparam int LPMD_WAKE_DLY = 8;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_GATE_DLY = 3'd2,
        ST_SLEEP    = 3'd3,
        ST_SNOOP    = 3'd4,
        ST_WAKE     = 3'd5
    } lpmd_state_e;

endpackage

// File: rtl/ct_clk_lpmd_cnt.sv
// Loadable down-counter shared by the gate-off delay and wake-up settling.
// Stops at zero rather than wrapping.
module ct_clk_lpmd_cnt
    import ct_clk_lpmd_pkg::*;
#(
    parameter int CNT_W = LPMD_CNT_W
) (
    input  logic             forever_coreclk,
    input  logic             cpurst_b,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over decrement; decrement only while nonzero.
    always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ct_clk_lpmd_ctrl.sv
// Low-power-mode sequencer feeding the core global ICG enable.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | clock on, core running
// DRAIN    | WFI retired, waiting for the bus to go idle
// GATE_DLY | bus idle, counting down before the clock is gated
// SLEEP    | clock gated, lpmd_ack asserted
// SNOOP    | clock on to service a snoop while still asleep
// WAKE     | clock on, settling before lpmd_wakeup_done is pulsed
module ct_clk_lpmd_ctrl
    import ct_clk_lpmd_pkg::*;
#(
    parameter int OFF_DLY  = LPMD_OFF_DLY,
    parameter int WAKE_DLY = LPMD_WAKE_DLY,
    parameter int CNT_W    = LPMD_CNT_W
) (
    input  logic       forever_coreclk,
    input  logic       cpurst_b,
    input  logic       rtu_lpmd_req,
    input  logic       biu_bus_idle,
    input  logic       int_wakeup,
    input  logic       dbg_wakeup,
    input  logic       snoop_req,
    input  logic       snoop_done,
    output logic       clk_lpmd_normal_work,
    output logic       clk_lpmd_snoop_vld,
    output logic       lpmd_ack,
    output logic       lpmd_wakeup_done,
    output logic [2:0] lpmd_state
);

    localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(OFF_DLY - 1);
    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_DLY - 1);

    lpmd_state_e      state_q, state_d;
    logic             wake;
    logic             wake_pend_q, wake_pend_d;
    logic             req_seen_q, req_seen_d;
    logic             done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign wake = int_wakeup | dbg_wakeup;

    ct_clk_lpmd_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .forever_coreclk (forever_coreclk),
        .cpurst_b        (cpurst_b),
        .load            (cnt_load),
        .load_val        (cnt_val),
        .dec             (cnt_dec),
        .zero            (cnt_zero)
    );

    // Next-state decode, counter control and sticky wake/request tracking.
    always_comb begin
        state_d     = state_q;
        wake_pend_d = 1'b0;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = WAKE_LD;
        case (state_q)
            ST_RUN: begin
                if (rtu_lpmd_req && !wake && !req_seen_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wake || !rtu_lpmd_req) begin
                    state_d = ST_WAKE;
                end else if (biu_bus_idle) begin
                    state_d  = ST_GATE_DLY;
                    cnt_load = 1'b1;
                    cnt_val  = OFF_LD;
                end
            end
            ST_GATE_DLY: begin
                cnt_dec = 1'b1;
                if (wake || !rtu_lpmd_req) state_d = ST_WAKE;
                else if (!biu_bus_idle)    state_d = ST_DRAIN;
                else if (cnt_zero)         state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (wake)           state_d = ST_WAKE;
                else if (snoop_req) state_d = ST_SNOOP;
            end
            ST_SNOOP: begin
                // A wake arriving mid-snoop is parked until the snoop completes.
                if (snoop_done) state_d = (wake || wake_pend_q) ? ST_WAKE : ST_SLEEP;
                else            wake_pend_d = wake_pend_q | wake;
            end
            ST_WAKE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if ((state_d == ST_WAKE) && (state_q != ST_WAKE)) begin
            cnt_load = 1'b1;
            cnt_val  = WAKE_LD;
        end

        // A request still held after wake-up must drop once before it counts again.
        if (!rtu_lpmd_req)                                  req_seen_d = 1'b0;
        else if ((state_q == ST_RUN) && (state_d == ST_DRAIN)) req_seen_d = 1'b1;
        else                                                req_seen_d = req_seen_q;
    end

    // State and outputs registered from the next-state decode so the ICG enable is glitch-free.
    always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q              <= ST_RUN;
            wake_pend_q          <= 1'b0;
            req_seen_q           <= 1'b0;
            clk_lpmd_normal_work <= 1'b1;
            clk_lpmd_snoop_vld   <= 1'b0;
            lpmd_ack             <= 1'b0;
            lpmd_wakeup_done     <= 1'b0;
        end else begin
            state_q              <= state_d;
            wake_pend_q          <= wake_pend_d;
            req_seen_q           <= req_seen_d;
            clk_lpmd_normal_work <= (state_d != ST_SLEEP);
            clk_lpmd_snoop_vld   <= (state_d == ST_SNOOP);
            lpmd_ack             <= (state_d == ST_SLEEP) || (state_d == ST_SNOOP);
            lpmd_wakeup_done     <= done_d;
        end
    end

    assign lpmd_state = state_q;

endmodule

// File: tb/tb_ct_clk_lpmd_ctrl.sv
// Bench for the low-power-mode sequencer: stimulus pushes the expected
// post-edge outputs from a timestamp-based reference model; a monitor pops
// and compares one entry per clock.
module tb_ct_clk_lpmd_ctrl;

    localparam int OFF_DLY  = 4;
    localparam int WAKE_DLY = 8;

    localparam int M_RUN = 0, M_DRAIN = 1, M_GATE = 2, M_SLEEP = 3, M_SNOOP = 4, M_WAKE = 5;

    typedef struct packed {
        logic [2:0] st;
        logic       nw;
        logic       vld;
        logic       ack;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       cpurst_b = 1'b1;
    logic       rtu_lpmd_req = 1'b0, biu_bus_idle = 1'b0, int_wakeup = 1'b0;
    logic       dbg_wakeup = 1'b0, snoop_req = 1'b0, snoop_done = 1'b0;
    logic       clk_lpmd_normal_work, clk_lpmd_snoop_vld, lpmd_ack, lpmd_wakeup_done;
    logic [2:0] lpmd_state;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    bit   rst_drv  = 1'b0;

    // reference model
    int md = M_RUN;
    int t_now = 0;
    int gate_t0 = 0;
    int wake_t0 = 0;
    bit m_pend = 1'b0;
    bit m_block = 1'b0;
    bit m_done = 1'b0;

    ct_clk_lpmd_ctrl #(.OFF_DLY(OFF_DLY), .WAKE_DLY(WAKE_DLY), .CNT_W(4)) dut (
        .forever_coreclk      (clk),
        .cpurst_b             (cpurst_b),
        .rtu_lpmd_req         (rtu_lpmd_req),
        .biu_bus_idle         (biu_bus_idle),
        .int_wakeup           (int_wakeup),
        .dbg_wakeup           (dbg_wakeup),
        .snoop_req            (snoop_req),
        .snoop_done           (snoop_done),
        .clk_lpmd_normal_work (clk_lpmd_normal_work),
        .clk_lpmd_snoop_vld   (clk_lpmd_snoop_vld),
        .lpmd_ack             (lpmd_ack),
        .lpmd_wakeup_done     (lpmd_wakeup_done),
        .lpmd_state           (lpmd_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        md = M_RUN; m_pend = 0; m_block = 0; m_done = 0;
    endtask

    task automatic enter_wake();
        md = M_WAKE;
        wake_t0 = t_now;
    endtask

    // One clock edge of the reference behaviour; t_now is the edge index.
    // Gate-off ends OFF_DLY edges after entering the delay; wake-up completes
    // WAKE_DLY edges after the wake is taken.
    task automatic model_step(input bit r, input bit i, input bit iw, input bit dw,
                              input bit sr, input bit sd);
        bit w;
        w = iw | dw;
        m_done = 0;
        case (md)
            M_RUN:   if (r && !w && !m_block) begin md = M_DRAIN; m_block = 1; end
            M_DRAIN: if (w || !r) enter_wake();
                     else if (i) begin md = M_GATE; gate_t0 = t_now; end
            M_GATE:  if (w || !r) enter_wake();
                     else if (!i) md = M_DRAIN;
                     else if (t_now - gate_t0 == OFF_DLY) md = M_SLEEP;
            M_SLEEP: if (w) enter_wake();
                     else if (sr) begin md = M_SNOOP; m_pend = 0; end
            M_SNOOP: if (sd) begin
                         if (w || m_pend) enter_wake(); else md = M_SLEEP;
                     end else if (w) m_pend = 1;
            M_WAKE:  if (t_now - wake_t0 == WAKE_DLY) begin md = M_RUN; m_done = 1; end
            default: md = M_RUN;
        endcase
        if (!r) m_block = 0;
    endtask

    task automatic step(input bit r, input bit i, input bit iw, input bit dw,
                        input bit sr, input bit sd);
        exp_t e;
        @(negedge clk);
        cpurst_b     = rst_drv;
        rtu_lpmd_req = r; biu_bus_idle = i; int_wakeup = iw;
        dbg_wakeup   = dw; snoop_req = sr; snoop_done = sd;
        t_now++;
        if (!rst_drv) model_reset();
        else          model_step(r, i, iw, dw, sr, sd);
        e.st   = 3'(md);
        e.nw   = (md != M_SLEEP);
        e.vld  = (md == M_SNOOP);
        e.ack  = (md == M_SLEEP) || (md == M_SNOOP);
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string nm);
        exp_t got;
        got = {lpmd_state, clk_lpmd_normal_work, clk_lpmd_snoop_vld, lpmd_ack, lpmd_wakeup_done};
        chk_cnt++;
        if (got === 7'b000_1_0_0_0) pass_cnt++;
        else $display("FAIL %s: got st=%0d nw=%b vld=%b ack=%b done=%b, want st=0 nw=1 vld=0 ack=0 done=0",
                      nm, got.st, got.nw, got.vld, got.ack, got.done);
    endtask

    // Asynchronous reset mid-run: outputs must snap to reset values before any edge.
    task automatic rst_pulse();
        rst_drv = 0;
        step(0, 0, 0, 0, 0, 0);
        #1 check_reset_vals("async_reset");
        step(0, 0, 0, 0, 0, 0);
        rst_drv = 1;
    endtask

    task automatic hold(input int n, input bit r, input bit i);
        repeat (n) step(r, i, 0, 0, 0, 0);
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {lpmd_state, clk_lpmd_normal_work, clk_lpmd_snoop_vld, lpmd_ack, lpmd_wakeup_done};
                chk_cnt++;
                if (got === e) pass_cnt++;
                else $display("FAIL outputs @%0t: got st=%0d nw=%b vld=%b ack=%b done=%b, want st=%0d nw=%b vld=%b ack=%b done=%b",
                              $time, got.st, got.nw, got.vld, got.ack, got.done,
                              e.st, e.nw, e.vld, e.ack, e.done);
            end
        end
    end

    initial begin
        #1 cpurst_b = 1'b0;
        #2 check_reset_vals("power_on_reset");
        rst_drv = 0;
        hold(2, 0, 0);
        rst_drv = 1;
        hold(2, 0, 0);

        // basic sleep, then interrupt wake
        hold(10, 1, 1);
        step(1, 1, 1, 0, 0, 0);
        hold(WAKE_DLY + 3, 1, 1);
        // request still high after wake: must stay in RUN until it drops
        hold(2, 0, 1);

        // busy bus during the gate-off delay
        hold(3, 1, 1);
        hold(1, 1, 0);
        hold(2, 1, 1);
        hold(1, 1, 0);
        hold(9, 1, 1);

        // snoop in sleep
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        hold(3, 1, 1);

        // wake during snoop, snoop_done three cycles later
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 0);
        hold(2, 1, 1);
        step(1, 1, 0, 0, 0, 1);
        hold(WAKE_DLY + 2, 0, 1);

        // snoop_done and wake together
        hold(10, 1, 1);
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0, 1);
        hold(WAKE_DLY + 2, 0, 1);

        // reset while asleep
        hold(10, 1, 1);
        rst_pulse();
        hold(2, 0, 0);

        // WFI abort in the gate-off delay
        hold(3, 1, 1);
        hold(WAKE_DLY + 3, 0, 1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(999) < 2) rst_pulse();
            else step($urandom_range(99) < 88, $urandom_range(99) < 80,
                      $urandom_range(99) < 3,  $urandom_range(99) < 2,
                      $urandom_range(99) < 15, $urandom_range(99) < 25);
        end

        @(posedge clk);
        #2;
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
